// File: rtl/tt_bist_pkg.sv
// Shared types and defaults for the Tiny Tapeout BIST harness.
// The parity helper covers buses up to PARITY_W bits wide.
package tt_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam logic [7:0]  DEFAULT_SEED      = 8'h01;
    localparam logic [7:0]  DEFAULT_LFSR_TAPS = 8'hB8;
    localparam logic [15:0] DEFAULT_SIG_TAPS  = 16'h002D;

    localparam int PARITY_W = 64;

    function automatic logic parity(input logic [PARITY_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/tt_bist_misr.sv
// Multiple-input signature register: folds one response word per enabled cycle.
// Kept standalone so it can be reused as an output-only signature probe.
module tt_bist_misr
    import tt_bist_pkg::*;
#(
    parameter int                SIG_W    = 16,
    parameter int                DATA_W   = 8,
    parameter logic [SIG_W-1:0]  SIG_TAPS = DEFAULT_SIG_TAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    logic fb;

    assign fb = parity(PARITY_W'(sig & SIG_TAPS));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], fb} ^ SIG_W'(din);
        end
    end

endmodule

// File: rtl/tt_bist_harness.sv
// On-chip self-test: LFSR stimulus generator, latency-aligned MISR capture
// and golden-signature compare for a Tiny Tapeout user design.
module tt_bist_harness
    import tt_bist_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                SIG_W     = 16,
    parameter int                PATTERNS  = 256,
    parameter int                LATENCY   = 1,
    parameter logic [DATA_W-1:0] SEED      = DEFAULT_SEED,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DEFAULT_LFSR_TAPS,
    parameter logic [SIG_W-1:0]  SIG_TAPS  = DEFAULT_SIG_TAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [SIG_W-1:0]  golden,
    input  logic [DATA_W-1:0] dut_out,
    output logic [DATA_W-1:0] stim,
    output logic              stim_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature
);

    localparam int CNT_W = $clog2(PATTERNS + 1);

    bist_state_t      state;
    logic [CNT_W-1:0] pat_cnt;
    logic [3:0]       drain_cnt;
    logic             lfsr_fb;
    logic             last_pattern;
    logic             drain_end;
    logic             cap_en;
    logic             misr_clear;
    logic [SIG_W-1:0] sig_next;

    assign lfsr_fb      = parity(PARITY_W'(stim & LFSR_TAPS));
    assign last_pattern = (pat_cnt == CNT_W'(PATTERNS - 1));
    assign drain_end    = (drain_cnt == 4'(LATENCY - 1));
    assign misr_clear   = abort || (start && (state == IDLE || state == DONE));

    // Value the MISR will hold after this edge, so pass can be decided on the
    // same edge that folds in the final response word.
    assign sig_next = cap_en
        ? ({signature[SIG_W-2:0], parity(PARITY_W'(signature & SIG_TAPS))} ^ SIG_W'(dut_out))
        : signature;

    // Capture strobe is stim_valid aligned to when the DUT response appears.
    generate
        if (LATENCY == 0) begin : g_cap_direct
            assign cap_en = stim_valid;
        end else begin : g_cap_delay
            logic [LATENCY-1:0] cap_pipe;

            always_ff @(posedge clk) begin
                if (rst || abort) begin
                    cap_pipe <= '0;
                end else begin
                    cap_pipe <= (cap_pipe << 1) | LATENCY'(stim_valid);
                end
            end

            assign cap_en = cap_pipe[LATENCY-1];
        end
    endgenerate

    tt_bist_misr #(
        .SIG_W    (SIG_W),
        .DATA_W   (DATA_W),
        .SIG_TAPS (SIG_TAPS)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (misr_clear),
        .en    (cap_en),
        .din   (dut_out),
        .sig   (signature)
    );

    // Control FSM; the final RUN edge does not step the LFSR so stim holds its
    // last counted vector while the pipeline drains.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state      <= IDLE;
            stim       <= SEED;
            pat_cnt    <= '0;
            drain_cnt  <= '0;
            stim_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        stim       <= SEED;
                        pat_cnt    <= '0;
                        drain_cnt  <= '0;
                        stim_valid <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                RUN: begin
                    pat_cnt <= pat_cnt + CNT_W'(1);
                    if (last_pattern) begin
                        stim_valid <= 1'b0;
                        if (LATENCY == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_next == golden);
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        stim <= {stim[DATA_W-2:0], lfsr_fb};
                    end
                end
                DRAIN: begin
                    if (drain_end) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (sig_next == golden);
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_bist_harness.sv
// Self-checking bench for tt_bist_harness: directed loopback scenarios plus a
// randomized-response run checked against a cycle-window signature model.
module tb_tt_bist_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: PATTERNS=4, LATENCY=1, registered loopback DUT
    logic        start_a, abort_a;
    logic [15:0] golden_a, sig_a;
    logic [7:0]  dut_out_a, stim_a;
    logic        stim_valid_a, busy_a, done_a, pass_a;

    // Instance B: PATTERNS=4, LATENCY=0, combinational loopback DUT
    logic        start_b, abort_b;
    logic [15:0] golden_b, sig_b;
    logic [7:0]  dut_out_b, stim_b;
    logic        stim_valid_b, busy_b, done_b, pass_b;

    // Instance C: PATTERNS=20, LATENCY=3, random responses
    localparam int PC = 20;
    localparam int LC = 3;
    logic        start_c, abort_c;
    logic [15:0] golden_c, sig_c;
    logic [7:0]  dut_out_c, stim_c;
    logic        stim_valid_c, busy_c, done_c, pass_c;

    int errors = 0;
    int checks = 0;

    logic [7:0]  plan_stim [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    logic [7:0]  rnd_c [PC+LC+1];
    logic [15:0] exp_sig_c;

    always @(posedge clk) dut_out_a <= stim_a;
    assign dut_out_b = stim_b;

    tt_bist_harness #(.PATTERNS(4), .LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .golden(golden_a),
        .dut_out(dut_out_a), .stim(stim_a), .stim_valid(stim_valid_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .signature(sig_a)
    );

    tt_bist_harness #(.PATTERNS(4), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .golden(golden_b),
        .dut_out(dut_out_b), .stim(stim_b), .stim_valid(stim_valid_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .signature(sig_b)
    );

    tt_bist_harness #(.PATTERNS(PC), .LATENCY(LC)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .golden(golden_c),
        .dut_out(dut_out_c), .stim(stim_c), .stim_valid(stim_valid_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .signature(sig_c)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    function automatic logic [15:0] misr_fold(input logic [15:0] s, input logic [7:0] d);
        return {s[14:0], ^(s & 16'h002D)} ^ {8'h00, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (stim_a !== 8'h01) begin errors++; $display("[TB] FAIL reset_stim: got %h expected 01", stim_a); end
        checks++; if (sig_a !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sig: got %h expected 0000", sig_a); end
        checks++; if ({stim_valid_a, busy_a, done_a, pass_a} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {stim_valid_a, busy_a, done_a, pass_a}); end
        checks++; if (stim_c !== 8'h01 || busy_c !== 1'b0) begin errors++; $display("[TB] FAIL reset_c: got stim=%h busy=%b expected stim=01 busy=0", stim_c, busy_c); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_loopback(input logic [15:0] g, input logic exp_pass);
        golden_a = g;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (stim_a !== plan_stim[k]) begin errors++; $display("[TB] FAIL loop_stim[%0d]: got %h expected %h", k, stim_a, plan_stim[k]); end
            checks++; if ({stim_valid_a, busy_a, done_a} !== 3'b110) begin errors++; $display("[TB] FAIL loop_run_flags[%0d]: got %b expected 110", k, {stim_valid_a, busy_a, done_a}); end
            step();
        end
        checks++; if ({stim_valid_a, busy_a, done_a} !== 3'b010) begin errors++; $display("[TB] FAIL loop_drain_flags: got %b expected 010", {stim_valid_a, busy_a, done_a}); end
        step();
        checks++; if ({busy_a, done_a} !== 2'b01) begin errors++; $display("[TB] FAIL loop_done_flags: got %b expected 01", {busy_a, done_a}); end
        checks++; if (sig_a !== 16'h0006) begin errors++; $display("[TB] FAIL loop_sig: got %h expected 0006", sig_a); end
        checks++; if (pass_a !== exp_pass) begin errors++; $display("[TB] FAIL loop_pass: got %b expected %b", pass_a, exp_pass); end
    endtask

    task automatic test_latency0();
        golden_b = 16'h0006;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (stim_b !== plan_stim[k] || stim_valid_b !== 1'b1 || busy_b !== 1'b1) begin errors++; $display("[TB] FAIL lat0_run[%0d]: got stim=%h valid=%b busy=%b expected stim=%h valid=1 busy=1", k, stim_b, stim_valid_b, busy_b, plan_stim[k]); end
            step();
        end
        checks++; if ({busy_b, done_b} !== 2'b01) begin errors++; $display("[TB] FAIL lat0_no_drain: got busy,done=%b expected 01", {busy_b, done_b}); end
        checks++; if (sig_b !== 16'h0006) begin errors++; $display("[TB] FAIL lat0_sig: got %h expected 0006", sig_b); end
        checks++; if (pass_b !== 1'b1) begin errors++; $display("[TB] FAIL lat0_pass: got %b expected 1", pass_b); end
    endtask

    task automatic test_abort();
        golden_a = 16'h0006;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        checks++; if (busy_a !== 1'b1 || sig_a !== 16'h0001) begin errors++; $display("[TB] FAIL abort_pre: got busy=%b sig=%h expected busy=1 sig=0001", busy_a, sig_a); end
        abort_a = 1'b1;
        start_a = 1'b1;
        step();
        abort_a = 1'b0;
        start_a = 1'b0;
        checks++; if ({stim_valid_a, busy_a, done_a, pass_a} !== 4'b0000) begin errors++; $display("[TB] FAIL abort_flags: got %b expected 0000", {stim_valid_a, busy_a, done_a, pass_a}); end
        checks++; if (sig_a !== 16'h0000) begin errors++; $display("[TB] FAIL abort_sig: got %h expected 0000", sig_a); end
        checks++; if (stim_a !== 8'h01) begin errors++; $display("[TB] FAIL abort_stim: got %h expected 01", stim_a); end
        step();
        step();
        checks++; if (sig_a !== 16'h0000 || busy_a !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle_hold: got sig=%h busy=%b expected sig=0000 busy=0", sig_a, busy_a); end
    endtask

    task automatic test_back_to_back();
        golden_a = 16'h0006;
        start_a = 1'b1;
        step();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (stim_a !== plan_stim[k] || busy_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("[TB] FAIL b2b_run[%0d][%0d]: got stim=%h busy=%b done=%b expected stim=%h busy=1 done=0", r, k, stim_a, busy_a, done_a, plan_stim[k]); end
                if (k == 0) begin
                    checks++; if (sig_a !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_sig_cleared[%0d]: got %h expected 0000", r, sig_a); end
                end
                step();
            end
            checks++; if ({busy_a, done_a} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_drain[%0d]: got %b expected 10", r, {busy_a, done_a}); end
            step();
            checks++; if (done_a !== 1'b1 || sig_a !== 16'h0006 || pass_a !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done[%0d]: got done=%b sig=%h pass=%b expected done=1 sig=0006 pass=1", r, done_a, sig_a, pass_a); end
            if (r == 1) start_a = 1'b0;
            else step();
        end
        step();
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("[TB] FAIL b2b_hold_done: got done=%b busy=%b expected done=1 busy=0", done_a, busy_a); end
    endtask

    task automatic test_reset_in_drain();
        golden_a = 16'h0006;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (4) step();
        checks++; if ({stim_valid_a, busy_a, done_a} !== 3'b010) begin errors++; $display("[TB] FAIL rstdrain_pre: got %b expected 010", {stim_valid_a, busy_a, done_a}); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (stim_a !== 8'h01 || sig_a !== 16'h0000) begin errors++; $display("[TB] FAIL rstdrain_regs: got stim=%h sig=%h expected stim=01 sig=0000", stim_a, sig_a); end
        checks++; if ({stim_valid_a, busy_a, done_a, pass_a} !== 4'b0000) begin errors++; $display("[TB] FAIL rstdrain_flags: got %b expected 0000", {stim_valid_a, busy_a, done_a, pass_a}); end
        step();
        test_loopback(16'h0006, 1'b1);
    endtask

    // Responses present in cycles LC+1 .. PC+LC after the start edge are folded.
    task automatic run_c(input logic [15:0] g);
        logic [7:0] s;
        golden_c = g;
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        s = 8'h01;
        for (int k = 1; k <= PC + LC; k++) begin
            dut_out_c = rnd_c[k];
            checks++; if (busy_c !== 1'b1 || done_c !== 1'b0) begin errors++; $display("[TB] FAIL rand_busy[%0d]: got busy=%b done=%b expected busy=1 done=0", k, busy_c, done_c); end
            if (k <= PC) begin
                checks++; if (stim_c !== s || stim_valid_c !== 1'b1) begin errors++; $display("[TB] FAIL rand_stim[%0d]: got %h valid=%b expected %h valid=1", k, stim_c, stim_valid_c, s); end
                s = lfsr_step(s);
            end else begin
                checks++; if (stim_valid_c !== 1'b0) begin errors++; $display("[TB] FAIL rand_drain_valid[%0d]: got %b expected 0", k, stim_valid_c); end
            end
            step();
        end
        dut_out_c = 8'($urandom_range(0, 255));
        checks++; if (done_c !== 1'b1 || busy_c !== 1'b0) begin errors++; $display("[TB] FAIL rand_done: got done=%b busy=%b expected done=1 busy=0", done_c, busy_c); end
        checks++; if (sig_c !== exp_sig_c) begin errors++; $display("[TB] FAIL rand_sig: got %h expected %h", sig_c, exp_sig_c); end
        checks++; if (pass_c !== (exp_sig_c == g)) begin errors++; $display("[TB] FAIL rand_pass: got %b expected %b", pass_c, (exp_sig_c == g)); end
    endtask

    task automatic test_random();
        for (int k = 0; k <= PC + LC; k++) rnd_c[k] = 8'($urandom_range(0, 255));
        exp_sig_c = 16'h0000;
        for (int k = LC + 1; k <= PC + LC; k++) exp_sig_c = misr_fold(exp_sig_c, rnd_c[k]);
        run_c(exp_sig_c ^ 16'h8001);
        run_c(exp_sig_c);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; golden_a = 16'h0000;
        start_b = 1'b0; abort_b = 1'b0; golden_b = 16'h0000;
        start_c = 1'b0; abort_c = 1'b0; golden_c = 16'h0000; dut_out_c = 8'h00;
        test_reset();
        test_loopback(16'h0006, 1'b1);
        test_loopback(16'h0007, 1'b0);
        test_latency0();
        test_abort();
        test_back_to_back();
        test_reset_in_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
